// File: rtl/csi2_line_packer.sv
// Store-and-forward line buffer between the ROIC read-out stream and the CSI-2 TX.
// Re-emits complete lines as FS / (LS, payload, LE) x N / FE and flags line-length and overrun errors.
module csi2_line_packer #(
    parameter int DATA_W  = 24,
    parameter int FIFO_AW = 12,
    parameter int LQ_AW   = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [15:0]         cfg_h_words,
    input  logic [15:0]         cfg_v_lines,
    input  logic                s_frame_start,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data_a,
    input  logic [DATA_W-1:0]   s_data_b,
    input  logic                s_tlast,
    output logic                s_tready,
    output logic                hdr_valid,
    output logic [1:0]          hdr_type,
    output logic [15:0]         hdr_wc,
    input  logic                hdr_ready,
    output logic                pl_valid,
    output logic [2*DATA_W-1:0] pl_data,
    output logic                pl_last,
    input  logic                pl_ready,
    output logic                frame_done,
    output logic                err_line_len,
    output logic                err_overrun
);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int LQ_DEPTH   = 1 << LQ_AW;
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [LQ_AW:0]   LQ_FULL   = (LQ_AW+1)'(LQ_DEPTH);

    localparam logic [1:0] HDR_FS = 2'd0;
    localparam logic [1:0] HDR_FE = 2'd1;
    localparam logic [1:0] HDR_LS = 2'd2;
    localparam logic [1:0] HDR_LE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FS, ST_WAIT, ST_LS, ST_PAY, ST_LE, ST_FE
    } state_t;

    logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [15:0]         lq_mem   [LQ_DEPTH];

    state_t             state_q, state_d;
    logic [FIFO_AW-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d, fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [FIFO_AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [LQ_AW-1:0]   lq_wr_ptr_q, lq_wr_ptr_d, lq_rd_ptr_q, lq_rd_ptr_d;
    logic [LQ_AW:0]     lq_cnt_q, lq_cnt_d;
    logic [15:0]        in_cnt_q, in_cnt_d;
    logic [15:0]        lines_sent_q, lines_sent_d;
    logic [15:0]        pay_cnt_q, pay_cnt_d;
    logic [15:0]        cfg_h_q, cfg_h_d, cfg_v_q, cfg_v_d;
    logic               s_tready_q, s_tready_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [1:0]         hdr_type_q, hdr_type_d;
    logic [15:0]        hdr_wc_q, hdr_wc_d;
    logic               frame_done_q, frame_done_d;
    logic               err_line_len_q, err_line_len_d;
    logic               err_overrun_q, err_overrun_d;

    logic        overrun, fifo_push, lq_push, pl_valid_int, pl_last_int, pl_fire, lq_pop;
    logic [15:0] in_cnt_inc;

    assign overrun      = s_frame_start && (state_q != ST_IDLE);
    assign fifo_push    = s_valid && s_tready_q && !overrun;
    assign lq_push      = fifo_push && s_tlast;
    assign in_cnt_inc   = (in_cnt_q == 16'hFFFF) ? in_cnt_q : in_cnt_q + 16'd1;
    assign pl_valid_int = (state_q == ST_PAY) && (fifo_cnt_q != '0);
    assign pl_last_int  = (pay_cnt_q == hdr_wc_q - 16'd1);
    assign pl_fire      = pl_valid_int && pl_ready;
    assign lq_pop       = pl_fire && pl_last_int;

    // Buffers, input counter, sticky flags and input ready.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        fifo_wr_ptr_d  = fifo_wr_ptr_q;
        fifo_rd_ptr_d  = fifo_rd_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        lq_wr_ptr_d    = lq_wr_ptr_q;
        lq_rd_ptr_d    = lq_rd_ptr_q;
        lq_cnt_d       = lq_cnt_q;
        in_cnt_d       = in_cnt_q;
        cfg_h_d        = s_frame_start ? cfg_h_words : cfg_h_q;
        cfg_v_d        = s_frame_start ? cfg_v_lines : cfg_v_q;
        err_overrun_d  = err_overrun_q || overrun;
        err_line_len_d = err_line_len_q;

        if (s_frame_start && state_q == ST_IDLE) begin
            err_line_len_d = 1'b0;
        end
        if (lq_push && in_cnt_inc != cfg_h_d) begin
            err_line_len_d = 1'b1;
        end

        if (overrun) begin
            fifo_wr_ptr_d = '0;
            fifo_rd_ptr_d = '0;
            fifo_cnt_d    = '0;
            lq_wr_ptr_d   = '0;
            lq_rd_ptr_d   = '0;
            lq_cnt_d      = '0;
            in_cnt_d      = '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr_d = fifo_wr_ptr_q + FIFO_AW'(1);
                in_cnt_d      = s_tlast ? 16'd0 : in_cnt_inc;
            end
            if (pl_fire) begin
                fifo_rd_ptr_d = fifo_rd_ptr_q + FIFO_AW'(1);
            end
            if (fifo_push && !pl_fire) begin
                fifo_cnt_d = fifo_cnt_q + (FIFO_AW+1)'(1);
            end else if (!fifo_push && pl_fire) begin
                fifo_cnt_d = fifo_cnt_q - (FIFO_AW+1)'(1);
            end
            if (lq_push) begin
                lq_wr_ptr_d = lq_wr_ptr_q + LQ_AW'(1);
            end
            if (lq_pop) begin
                lq_rd_ptr_d = lq_rd_ptr_q + LQ_AW'(1);
            end
            if (lq_push && !lq_pop) begin
                lq_cnt_d = lq_cnt_q + (LQ_AW+1)'(1);
            end else if (!lq_push && lq_pop) begin
                lq_cnt_d = lq_cnt_q - (LQ_AW+1)'(1);
            end
        end

        // Ready is computed from next-cycle occupancy, so the registered copy never admits a word into a full buffer.
        s_tready_d = (fifo_cnt_d != FIFO_FULL) && (lq_cnt_d != LQ_FULL);
    end

    // Output sequencer; any frame start restarts at FS, dropping whatever was pending.
    always_comb begin
        state_d      = state_q;
        hdr_valid_d  = hdr_valid_q;
        hdr_type_d   = hdr_type_q;
        hdr_wc_d     = hdr_wc_q;
        lines_sent_d = lines_sent_q;
        pay_cnt_d    = pay_cnt_q;
        frame_done_d = 1'b0;

        if (s_frame_start) begin
            state_d      = ST_FS;
            hdr_valid_d  = 1'b1;
            hdr_type_d   = HDR_FS;
            hdr_wc_d     = 16'd0;
            lines_sent_d = 16'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_FS: if (hdr_ready) begin
                    state_d     = ST_WAIT;
                    hdr_valid_d = 1'b0;
                end
                ST_WAIT: if (lq_cnt_q != '0) begin
                    state_d     = ST_LS;
                    hdr_valid_d = 1'b1;
                    hdr_type_d  = HDR_LS;
                    hdr_wc_d    = lq_mem[lq_rd_ptr_q];
                end
                ST_LS: if (hdr_ready) begin
                    state_d     = ST_PAY;
                    hdr_valid_d = 1'b0;
                    pay_cnt_d   = 16'd0;
                end
                ST_PAY: if (pl_fire) begin
                    if (pl_last_int) begin
                        state_d     = ST_LE;
                        hdr_valid_d = 1'b1;
                        hdr_type_d  = HDR_LE;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 16'd1;
                    end
                end
                ST_LE: if (hdr_ready) begin
                    lines_sent_d = lines_sent_q + 16'd1;
                    if (lines_sent_d == cfg_v_q) begin
                        state_d    = ST_FE;
                        hdr_type_d = HDR_FE;
                    end else begin
                        state_d     = ST_WAIT;
                        hdr_valid_d = 1'b0;
                    end
                end
                ST_FE: if (hdr_ready) begin
                    state_d      = ST_IDLE;
                    hdr_valid_d  = 1'b0;
                    frame_done_d = 1'b1;
                end
                default: begin
                    state_d     = ST_IDLE;
                    hdr_valid_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: storage arrays have no reset; occupancy counters alone decide which entries are meaningful.
    always_ff @(posedge sys_clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr_q] <= {s_data_a, s_data_b};
        end
        if (lq_push) begin
            lq_mem[lq_wr_ptr_q] <= in_cnt_inc;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            fifo_wr_ptr_q  <= '0;
            fifo_rd_ptr_q  <= '0;
            fifo_cnt_q     <= '0;
            lq_wr_ptr_q    <= '0;
            lq_rd_ptr_q    <= '0;
            lq_cnt_q       <= '0;
            in_cnt_q       <= '0;
            lines_sent_q   <= '0;
            pay_cnt_q      <= '0;
            cfg_h_q        <= '0;
            cfg_v_q        <= '0;
            s_tready_q     <= 1'b0;
            hdr_valid_q    <= 1'b0;
            hdr_type_q     <= 2'd0;
            hdr_wc_q       <= '0;
            frame_done_q   <= 1'b0;
            err_line_len_q <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            fifo_wr_ptr_q  <= fifo_wr_ptr_d;
            fifo_rd_ptr_q  <= fifo_rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            lq_wr_ptr_q    <= lq_wr_ptr_d;
            lq_rd_ptr_q    <= lq_rd_ptr_d;
            lq_cnt_q       <= lq_cnt_d;
            in_cnt_q       <= in_cnt_d;
            lines_sent_q   <= lines_sent_d;
            pay_cnt_q      <= pay_cnt_d;
            cfg_h_q        <= cfg_h_d;
            cfg_v_q        <= cfg_v_d;
            s_tready_q     <= s_tready_d;
            hdr_valid_q    <= hdr_valid_d;
            hdr_type_q     <= hdr_type_d;
            hdr_wc_q       <= hdr_wc_d;
            frame_done_q   <= frame_done_d;
            err_line_len_q <= err_line_len_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign s_tready     = s_tready_q;
    assign hdr_valid    = hdr_valid_q;
    assign hdr_type     = hdr_type_q;
    assign hdr_wc       = hdr_wc_q;
    assign pl_valid     = pl_valid_int;
    assign pl_data      = pl_valid_int ? fifo_mem[fifo_rd_ptr_q] : '0;
    assign pl_last      = pl_valid_int && pl_last_int;
    assign frame_done   = frame_done_q;
    assign err_line_len = err_line_len_q;
    assign err_overrun  = err_overrun_q;

endmodule
